// File: rtl/cpu_top_pkg.sv
// cpu_top_pkg: shared widths, instruction field positions and opcode
// encodings for the cpu_top SIMD core and its vector ALU.
// Optional feature macro: CPU_TOP_MUL_EN (scalar MUL / vector VMUL).
package cpu_top_pkg;

    localparam int INST_W  = 13;
    localparam int PC_W    = 10;
    localparam int DADDR_W = 4;
    localparam int SDATA_W = 16;
    localparam int LANE_W  = 4;
    localparam int LANES   = 4;
    localparam int NREG    = 8;
    localparam int RIDX_W  = 3;

    // Instruction field bit positions
    localparam int OP_LSB  = 0;
    localparam int OP_MSB  = 3;
    localparam int RS2_LSB = 4;
    localparam int RS2_MSB = 6;
    localparam int RS1_LSB = 7;
    localparam int RS1_MSB = 9;
    localparam int RD_LSB  = 10;
    localparam int RD_MSB  = 12;
    localparam int OFF_LSB = 4;
    localparam int OFF_MSB = 9;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_VADD  = 4'b0001,
        OP_SUB   = 4'b0010,
        OP_VSUB  = 4'b0011,
        OP_MUL   = 4'b0100,
        OP_VMUL  = 4'b0101,
        OP_BNEZ  = 4'b0110,
        OP_BEQZ  = 4'b0111,
        OP_LOAD  = 4'b1000,
        OP_VLOAD = 4'b1001,
        OP_ADDI  = 4'b1010
    } opcode_e;

    typedef enum logic [1:0] {
        VOP_ADD = 2'd0,
        VOP_SUB = 2'd1,
        VOP_MUL = 2'd2
    } vop_e;

endpackage

// File: rtl/cpu_top_vec_alu.sv
// cpu_top_vec_alu: 4-lane x 4-bit vector ALU, purely combinational.
// Ports: vop (operation select), a/b (packed lane operands, lane0 in the
// low nibble), y (packed lane results, each lane wrapping at 4 bits).
// Optional feature macro: CPU_TOP_MUL_EN enables the lane multipliers.
module cpu_top_vec_alu
    import cpu_top_pkg::*;
(
    input  vop_e                      vop,
    input  logic [LANES*LANE_W-1:0]   a,
    input  logic [LANES*LANE_W-1:0]   b,
    output logic [LANES*LANE_W-1:0]   y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < LANES; k++) begin
            case (vop)
                VOP_ADD: y[k*LANE_W +: LANE_W] = a[k*LANE_W +: LANE_W] + b[k*LANE_W +: LANE_W];
                VOP_SUB: y[k*LANE_W +: LANE_W] = a[k*LANE_W +: LANE_W] - b[k*LANE_W +: LANE_W];
`ifdef CPU_TOP_MUL_EN
                // Product truncated to the lane width
                VOP_MUL: y[k*LANE_W +: LANE_W] = a[k*LANE_W +: LANE_W] * b[k*LANE_W +: LANE_W];
`endif
                default: y[k*LANE_W +: LANE_W] = '0;
            endcase
        end
    end

endmodule

// File: rtl/cpu_top.sv
// cpu_top: single-cycle single-issue SIMD core. 8 x 16-bit scalar
// registers, 8 x (4 lanes x 4-bit) vector registers, read-only memories.
// Ports: clk, rst (synchronous, active-low); instruction_in / inst_addr
// (combinational instruction fetch, PC); data_addr / data_in (scalar
// memory); data_addr0..3 / data_in0..3 (vector lane memories).
// Optional feature macro: CPU_TOP_MUL_EN (MUL/VMUL; otherwise NOP).
module cpu_top
    import cpu_top_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INST_W-1:0]    instruction_in,
    output logic [PC_W-1:0]      inst_addr,
    output logic [DADDR_W-1:0]   data_addr,
    input  logic [SDATA_W-1:0]   data_in,
    output logic [DADDR_W-1:0]   data_addr0,
    output logic [DADDR_W-1:0]   data_addr1,
    output logic [DADDR_W-1:0]   data_addr2,
    output logic [DADDR_W-1:0]   data_addr3,
    input  logic [LANE_W-1:0]    data_in0,
    input  logic [LANE_W-1:0]    data_in1,
    input  logic [LANE_W-1:0]    data_in2,
    input  logic [LANE_W-1:0]    data_in3
);

    logic [SDATA_W-1:0]        sregs [NREG];
    logic [LANES*LANE_W-1:0]   vregs [NREG];

    opcode_e                   op;
    logic [RIDX_W-1:0]         rd, rs1, rs2;
    logic [2:0]                imm3;
    logic signed [5:0]         off6;
    logic signed [PC_W-1:0]    off_ext;

    logic [SDATA_W-1:0]        rs1_val, rs2_val, rd_val;
    logic [DADDR_W-1:0]        ld_base;

    logic                      s_we, v_we;
    logic [SDATA_W-1:0]        s_res;
    logic [LANES*LANE_W-1:0]   v_res, valu_y;
    vop_e                      vop;
    logic [PC_W-1:0]           pc_next;

    assign op      = opcode_e'(instruction_in[OP_MSB:OP_LSB]);
    assign rd      = instruction_in[RD_MSB:RD_LSB];
    assign rs1     = instruction_in[RS1_MSB:RS1_LSB];
    assign rs2     = instruction_in[RS2_MSB:RS2_LSB];
    assign imm3    = instruction_in[RS2_MSB:RS2_LSB];
    assign off6    = instruction_in[OFF_MSB:OFF_LSB];
    assign off_ext = {{(PC_W-6){off6[5]}}, off6};

    // R0 is never written, so reading it always yields the reset zero
    assign rs1_val = sregs[rs1];
    assign rs2_val = sregs[rs2];
    assign rd_val  = sregs[rd];
    assign ld_base = rs1_val[DADDR_W-1:0] + DADDR_W'(imm3);

    cpu_top_vec_alu u_vec_alu (
        .vop (vop),
        .a   (vregs[rs1]),
        .b   (vregs[rs2]),
        .y   (valu_y)
    );

    always_comb begin
        s_we       = 1'b0;
        v_we       = 1'b0;
        s_res      = '0;
        v_res      = valu_y;
        vop        = VOP_ADD;
        pc_next    = inst_addr + PC_W'(1);
        data_addr  = '0;
        data_addr0 = '0;
        data_addr1 = '0;
        data_addr2 = '0;
        data_addr3 = '0;
        case (op)
            OP_ADD:  begin s_we = 1'b1; s_res = rs1_val + rs2_val; end
            OP_SUB:  begin s_we = 1'b1; s_res = rs1_val - rs2_val; end
            OP_ADDI: begin s_we = 1'b1; s_res = rs1_val + SDATA_W'(imm3); end
            OP_VADD: begin v_we = 1'b1; vop = VOP_ADD; end
            OP_VSUB: begin v_we = 1'b1; vop = VOP_SUB; end
`ifdef CPU_TOP_MUL_EN
            OP_MUL:  begin s_we = 1'b1; s_res = rs1_val * rs2_val; end
            OP_VMUL: begin v_we = 1'b1; vop = VOP_MUL; end
`endif
            OP_BNEZ: if (rd_val != '0) pc_next = inst_addr + off_ext;
            OP_BEQZ: if (rd_val == '0) pc_next = inst_addr + off_ext;
            OP_LOAD: begin
                data_addr = ld_base;
                s_we      = 1'b1;
                s_res     = data_in;
            end
            OP_VLOAD: begin
                // Consecutive lane addresses wrap within the 16-entry space
                data_addr0 = ld_base;
                data_addr1 = ld_base + DADDR_W'(1);
                data_addr2 = ld_base + DADDR_W'(2);
                data_addr3 = ld_base + DADDR_W'(3);
                v_we       = 1'b1;
                v_res      = {data_in3, data_in2, data_in1, data_in0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_addr <= '0;
            for (int i = 0; i < NREG; i++) begin
                sregs[i] <= '0;
                vregs[i] <= '0;
            end
        end else begin
            inst_addr <= pc_next;
            if (s_we && (rd != '0)) sregs[rd] <= s_res;
            if (v_we)               vregs[rd] <= v_res;
        end
    end

endmodule

// File: tb/tb_cpu_top.sv
module tb_cpu_top;

`ifdef CPU_TOP_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam int O_ADD = 0, O_VADD = 1, O_SUB = 2, O_VSUB = 3, O_MUL = 4, O_VMUL = 5;
    localparam int O_BNEZ = 6, O_BEQZ = 7, O_LOAD = 8, O_VLOAD = 9, O_ADDI = 10, O_NOP = 15;

    logic        clk;
    logic        rst;
    logic [12:0] instruction_in;
    logic [9:0]  inst_addr;
    logic [3:0]  data_addr;
    logic [15:0] data_in;
    logic [3:0]  data_addr0, data_addr1, data_addr2, data_addr3;
    logic [3:0]  data_in0, data_in1, data_in2, data_in3;

    logic [15:0] smem [16];
    logic [3:0]  vmem [16];

    assign data_in  = smem[data_addr];
    assign data_in0 = vmem[data_addr0];
    assign data_in1 = vmem[data_addr1];
    assign data_in2 = vmem[data_addr2];
    assign data_in3 = vmem[data_addr3];

    cpu_top dut (
        .clk            (clk),
        .rst            (rst),
        .instruction_in (instruction_in),
        .inst_addr      (inst_addr),
        .data_addr      (data_addr),
        .data_in        (data_in),
        .data_addr0     (data_addr0),
        .data_addr1     (data_addr1),
        .data_addr2     (data_addr2),
        .data_addr3     (data_addr3),
        .data_in0       (data_in0),
        .data_in1       (data_in1),
        .data_in2       (data_in2),
        .data_in3       (data_in3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: architectural values as plain integers
    longint m_r [8];
    int     m_v [8][4];
    int     m_pc;
    logic [12:0] cur_ins;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return {3'(rd), 3'(rs1), 3'(rs2), 4'(op)};
    endfunction

    function automatic logic [12:0] enc_b(input int op, input int rd, input int off);
        logic [5:0] o;
        o = 6'(off);
        return {3'(rd), o, 4'(op)};
    endfunction

    task automatic model_reset();
        m_pc = 0;
        for (int i = 0; i < 8; i++) begin
            m_r[i] = 0;
            for (int k = 0; k < 4; k++) m_v[i][k] = 0;
        end
    endtask

    function automatic int vpack(input int r);
        return m_v[r][0] + 16 * m_v[r][1] + 256 * m_v[r][2] + 4096 * m_v[r][3];
    endfunction

    task automatic wr(input int rd, input longint val);
        if (rd != 0) m_r[rd] = val % 65536;
    endtask

    task automatic model_exec(input logic [12:0] ins);
        int x, op, rd, rs1, rs2, off, base;
        int t [4];
        x = int'(ins);
        op = x % 16; rs2 = (x / 16) % 8; rs1 = (x / 128) % 8; rd = x / 1024;
        off = (x / 16) % 64;
        if (off >= 32) off = off - 64;
        base = (int'(m_r[rs1] % 16) + rs2) % 16;
        m_pc = (m_pc + 1) % 1024;
        case (op)
            O_ADD:  wr(rd, m_r[rs1] + m_r[rs2]);
            O_SUB:  wr(rd, m_r[rs1] - m_r[rs2] + 65536);
            O_MUL:  if (MUL_EN) wr(rd, m_r[rs1] * m_r[rs2]);
            O_ADDI: wr(rd, m_r[rs1] + rs2);
            O_LOAD: wr(rd, longint'(smem[base]));
            O_BNEZ: if (m_r[rd] != 0) m_pc = (m_pc - 1 + off + 1024) % 1024;
            O_BEQZ: if (m_r[rd] == 0) m_pc = (m_pc - 1 + off + 1024) % 1024;
            O_VADD, O_VSUB, O_VMUL, O_VLOAD: begin
                for (int k = 0; k < 4; k++) begin
                    if (op == O_VADD)      t[k] = (m_v[rs1][k] + m_v[rs2][k]) % 16;
                    else if (op == O_VSUB) t[k] = (m_v[rs1][k] - m_v[rs2][k] + 16) % 16;
                    else if (op == O_VMUL) t[k] = (m_v[rs1][k] * m_v[rs2][k]) % 16;
                    else                   t[k] = int'(vmem[(base + k) % 16]);
                end
                if (op != O_VMUL || MUL_EN)
                    for (int k = 0; k < 4; k++) m_v[rd][k] = t[k];
            end
            default: ;
        endcase
    endtask

    task automatic check_regs();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("r%0d", i), 32'(dut.sregs[i]), 32'(m_r[i]));
            chk($sformatf("v%0d", i), 32'(dut.vregs[i]), 32'(vpack(i)));
        end
    endtask

    // Drive an instruction and check the combinational addresses
    task automatic present(input logic [12:0] ins);
        int x, op, rs1, rs2, base, ea;
        int ev [4];
        cur_ins = ins;
        instruction_in = ins;
        #1;
        x = int'(ins);
        op = x % 16; rs2 = (x / 16) % 8; rs1 = (x / 128) % 8;
        base = (int'(m_r[rs1] % 16) + rs2) % 16;
        ea = (op == O_LOAD) ? base : 0;
        for (int k = 0; k < 4; k++) ev[k] = (op == O_VLOAD) ? (base + k) % 16 : 0;
        chk("data_addr", 32'(data_addr), 32'(ea));
        chk("vec_addr", {16'd0, data_addr0, data_addr1, data_addr2, data_addr3},
            32'(ev[0] * 4096 + ev[1] * 256 + ev[2] * 16 + ev[3]));
    endtask

    // Clock edge, then advance the model and compare architectural state
    task automatic clock();
        @(posedge clk);
        #1;
        if (rst) model_exec(cur_ins);
        else     model_reset();
        chk("pc", 32'(inst_addr), 32'(m_pc));
        check_regs();
    endtask

    task automatic step(input logic [12:0] ins);
        present(ins);
        clock();
    endtask

    initial begin
        rst = 1'b0;
        instruction_in = enc(O_NOP, 0, 0, 0);
        cur_ins = instruction_in;
        for (int i = 0; i < 16; i++) begin
            smem[i] = (i <= 6) ? 16'(i) : 16'($urandom);
            vmem[i] = 4'($urandom);
        end
        vmem[0] = 0; vmem[1] = 1; vmem[2] = 2; vmem[3] = 3; vmem[4] = 4; vmem[5] = 0;
        vmem[6] = 1; vmem[7] = 2; vmem[8] = 3; vmem[9] = 4; vmem[10] = 5;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_pc", 32'(inst_addr), 32'd0);
        check_regs();
        rst = 1'b1;

        // Scalar ADDI and LOAD
        step(enc(O_ADDI, 1, 0, 1));
        chk("addi_r1", 32'(dut.sregs[1]), 32'd1);
        present(enc(O_LOAD, 3, 1, 4));
        chk("ld_addr", 32'(data_addr), 32'd5);
        clock();
        chk("ld_r3", 32'(dut.sregs[3]), 32'd5);

        // Vector loads and add
        present(enc(O_VLOAD, 5, 1, 0));
        chk("vld_addr_a", {16'd0, data_addr0, data_addr1, data_addr2, data_addr3}, 32'h1234);
        clock();
        chk("vld_v5", 32'(dut.vregs[5]), 32'h4321);
        present(enc(O_VLOAD, 2, 1, 3));
        chk("vld_addr_b", {16'd0, data_addr0, data_addr1, data_addr2, data_addr3}, 32'h4567);
        clock();
        chk("vld_v2", 32'(dut.vregs[2]), 32'h2104);
        step(enc(O_VADD, 2, 2, 5));
        chk("vadd_v2", 32'(dut.vregs[2]), 32'h6425);

        // Build {4,4,4,4} then VMUL with {4,0,1,2}
        step(enc(O_VLOAD, 6, 0, 0));
        step(enc(O_VSUB, 6, 5, 6));
        step(enc(O_VADD, 6, 6, 6));
        step(enc(O_VADD, 6, 6, 6));
        chk("v6_fours", 32'(dut.vregs[6]), 32'h4444);
        step(enc(O_VLOAD, 3, 0, 4));
        step(enc(O_VMUL, 7, 3, 6));
        chk("vmul_v7", 32'(dut.vregs[7]), MUL_EN ? 32'h8400 : 32'h0);
        chk("vmul_pc", 32'(inst_addr), 32'd11);

        // Reset mid-program discards the pending writeback
        rst = 1'b0;
        step(enc(O_ADDI, 5, 0, 7));
        rst = 1'b1;
        chk("midrst_r5", 32'(dut.sregs[5]), 32'd0);
        chk("midrst_pc", 32'(inst_addr), 32'd0);

        // Branches
        step(enc(O_ADDI, 2, 0, 3));
        repeat (5) step(enc(O_NOP, 0, 0, 0));
        step(enc_b(O_BNEZ, 2, -6));
        chk("bnez_taken", 32'(inst_addr), 32'd0);
        step(enc(O_SUB, 2, 2, 2));
        repeat (5) step(enc(O_NOP, 0, 0, 0));
        step(enc_b(O_BNEZ, 2, -6));
        chk("bnez_not", 32'(inst_addr), 32'd7);
        step(enc_b(O_BEQZ, 0, -8));
        chk("beqz_wrap_back", 32'(inst_addr), 32'd1023);
        step(enc_b(O_BNEZ, 2, -6));
        chk("pc_wrap_1023", 32'(inst_addr), 32'd0);
        step(enc_b(O_BEQZ, 0, -1));
        step(enc_b(O_BEQZ, 0, 1));
        chk("beqz_wrap_fwd", 32'(inst_addr), 32'd0);
        step(enc_b(O_BEQZ, 0, 0));
        step(enc_b(O_BEQZ, 0, 0));
        chk("self_loop", 32'(inst_addr), 32'd0);

        // Scalar wrap and R0
        step(enc(O_ADDI, 4, 0, 1));
        step(enc(O_SUB, 1, 0, 4));
        chk("r1_ffff", 32'(dut.sregs[1]), 32'hFFFF);
        step(enc(O_ADDI, 1, 1, 1));
        chk("r1_wrap", 32'(dut.sregs[1]), 32'd0);
        step(enc(O_ADD, 0, 4, 4));
        chk("r0_zero", 32'(dut.sregs[0]), 32'd0);

        // Randomized instruction stream with occasional resets
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 11);
            if (op == 11) op = O_NOP;
            rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            step({13'($urandom_range(0, 511)) << 4} | 13'(op));
        end
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
